// File: rtl/mem_bus_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the memory port arbiter.
// The master modport is the arbiter's view; slave is the view of the caches, DMA and memory.
interface mem_bus_arbiter_if #(
    parameter int WORD_SIZE  = 16,
    parameter int QWORD_SIZE = 64
);
    logic                  i_req;
    logic [WORD_SIZE-1:0]  i_addr;
    logic [WORD_SIZE-1:0]  i_size;
    logic                  i_gnt;
    logic                  i_ack;

    logic                  d_rd;
    logic                  d_wr;
    logic [WORD_SIZE-1:0]  d_addr;
    logic [WORD_SIZE-1:0]  d_size;
    logic [QWORD_SIZE-1:0] d_wdata;
    logic                  d_gnt;
    logic                  d_ack;

    logic                  dma_br;
    logic                  dma_bg;
    logic                  dma_wr;
    logic [WORD_SIZE-1:0]  dma_addr;
    logic [WORD_SIZE-1:0]  dma_size;
    logic [QWORD_SIZE-1:0] dma_wdata;
    logic                  dma_ack;

    logic                  m__read_m;
    logic                  m__write_m;
    logic [WORD_SIZE-1:0]  m__addr;
    logic [WORD_SIZE-1:0]  m__size;
    logic [QWORD_SIZE-1:0] m__wdata;
    logic                  m__ready;
    logic                  m__ack;

    modport master (
        input  i_req, i_addr, i_size,
        output i_gnt, i_ack,
        input  d_rd, d_wr, d_addr, d_size, d_wdata,
        output d_gnt, d_ack,
        input  dma_br, dma_wr, dma_addr, dma_size, dma_wdata,
        output dma_bg, dma_ack,
        output m__read_m, m__write_m, m__addr, m__size, m__wdata,
        input  m__ready, m__ack
    );

    modport slave (
        output i_req, i_addr, i_size,
        input  i_gnt, i_ack,
        output d_rd, d_wr, d_addr, d_size, d_wdata,
        input  d_gnt, d_ack,
        output dma_br, dma_wr, dma_addr, dma_size, dma_wdata,
        input  dma_bg, dma_ack,
        input  m__read_m, m__write_m, m__addr, m__size, m__wdata,
        output m__ready, m__ack
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between I-cache, D-cache and a bursting DMA engine.
// All outputs come straight from registers; the DMA holds the port across transfers.
module mem_bus_arbiter #(
    parameter int WORD_SIZE  = 16,
    parameter int QWORD_SIZE = 64,
    parameter bit CPU_FAIR   = 1'b1
) (
    input logic         clk,
    input logic         reset_n,
    mem_bus_arbiter_if.master bus
);
    typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, DMA_OWN, DMA_XFER} state_t;

    typedef struct packed {
        logic                  i_gnt;
        logic                  d_gnt;
        logic                  dma_bg;
        logic                  read_m;
        logic                  write_m;
        logic                  i_ack;
        logic                  d_ack;
        logic                  dma_ack;
        logic [WORD_SIZE-1:0]  addr;
        logic [WORD_SIZE-1:0]  size;
        logic [QWORD_SIZE-1:0] wdata;
    } out_t;

    state_t state_q, state_d;
    out_t   out_q, out_d;
    logic   rr_last_q, rr_last_d;   // 0 = I-cache served last, 1 = D-cache
    logic   dma_served_q, dma_served_d;

    logic i_pend, d_pend, cpu_pend, dma_pend, dma_win, pick_d;

    // A requester drops its level request on the edge where it samples its ack,
    // so during the ack cycle its request is stale and must not be re-granted.
    assign i_pend   = bus.i_req & ~out_q.i_ack;
    assign d_pend   = (bus.d_rd | bus.d_wr) & ~out_q.d_ack;
    assign dma_pend = bus.dma_wr & ~out_q.dma_ack;
    assign cpu_pend = i_pend | d_pend;
    assign dma_win  = bus.dma_br & ~(CPU_FAIR & dma_served_q & cpu_pend);
    assign pick_d   = d_pend & (~i_pend | ~rr_last_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            out_q        <= '0;
            rr_last_q    <= 1'b0;
            dma_served_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_q        <= out_d;
            rr_last_q    <= rr_last_d;
            dma_served_q <= dma_served_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        out_d         = out_q;
        rr_last_d     = rr_last_q;
        dma_served_d  = dma_served_q;
        out_d.i_ack   = 1'b0;
        out_d.d_ack   = 1'b0;
        out_d.dma_ack = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.m__ready) begin
                    if (dma_win) begin
                        state_d      = DMA_OWN;
                        out_d.dma_bg = 1'b1;
                        dma_served_d = 1'b1;
                    end else if (pick_d) begin
                        state_d       = BUSY_D;
                        out_d.d_gnt   = 1'b1;
                        out_d.write_m = bus.d_wr;
                        out_d.read_m  = ~bus.d_wr;
                        out_d.addr    = bus.d_addr;
                        out_d.size    = bus.d_size;
                        out_d.wdata   = bus.d_wr ? bus.d_wdata : '0;
                        rr_last_d     = 1'b1;
                        dma_served_d  = 1'b0;
                    end else if (i_pend) begin
                        state_d      = BUSY_I;
                        out_d.i_gnt  = 1'b1;
                        out_d.read_m = 1'b1;
                        out_d.addr   = bus.i_addr;
                        out_d.size   = bus.i_size;
                        out_d.wdata  = '0;
                        rr_last_d    = 1'b0;
                        dma_served_d = 1'b0;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                if (bus.m__ack) begin
                    state_d       = IDLE;
                    out_d.i_gnt   = 1'b0;
                    out_d.d_gnt   = 1'b0;
                    out_d.read_m  = 1'b0;
                    out_d.write_m = 1'b0;
                    out_d.i_ack   = (state_q == BUSY_I);
                    out_d.d_ack   = (state_q == BUSY_D);
                end
            end
            DMA_OWN: begin
                if (dma_pend && bus.m__ready) begin
                    state_d       = DMA_XFER;
                    out_d.write_m = 1'b1;
                    out_d.addr    = bus.dma_addr;
                    out_d.size    = bus.dma_size;
                    out_d.wdata   = bus.dma_wdata;
                end else if (!bus.dma_br && !dma_pend) begin
                    state_d      = IDLE;
                    out_d.dma_bg = 1'b0;
                end
            end
            DMA_XFER: begin
                if (bus.m__ack) begin
                    state_d       = DMA_OWN;
                    out_d.write_m = 1'b0;
                    out_d.dma_ack = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.i_gnt      = out_q.i_gnt;
    assign bus.i_ack      = out_q.i_ack;
    assign bus.d_gnt      = out_q.d_gnt;
    assign bus.d_ack      = out_q.d_ack;
    assign bus.dma_bg     = out_q.dma_bg;
    assign bus.dma_ack    = out_q.dma_ack;
    assign bus.m__read_m  = out_q.read_m;
    assign bus.m__write_m = out_q.write_m;
    assign bus.m__addr    = out_q.addr;
    assign bus.m__size    = out_q.size;
    assign bus.m__wdata   = out_q.wdata;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed cycle table plus hand sequences for fairness and mid-transaction reset.
// u_fair runs with CPU_FAIR=1, u_unfair with CPU_FAIR=0 on identical stimulus.
module tb_mem_bus_arbiter;
    localparam logic [63:0] DWD = 64'h1111_2222_3333_4444;
    localparam logic [63:0] XWD = 64'hA5A5_0000_0000_5A5A;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mem_bus_arbiter_if if0 ();
    mem_bus_arbiter_if if1 ();

    assign if1.i_req     = if0.i_req;
    assign if1.i_addr    = if0.i_addr;
    assign if1.i_size    = if0.i_size;
    assign if1.d_rd      = if0.d_rd;
    assign if1.d_wr      = if0.d_wr;
    assign if1.d_addr    = if0.d_addr;
    assign if1.d_size    = if0.d_size;
    assign if1.d_wdata   = if0.d_wdata;
    assign if1.dma_br    = if0.dma_br;
    assign if1.dma_wr    = if0.dma_wr;
    assign if1.dma_addr  = if0.dma_addr;
    assign if1.dma_size  = if0.dma_size;
    assign if1.dma_wdata = if0.dma_wdata;
    assign if1.m__ready  = if0.m__ready;
    assign if1.m__ack    = if0.m__ack;

    mem_bus_arbiter #(.CPU_FAIR(1'b1)) u_fair   (.clk(clk), .reset_n(reset_n), .bus(if0));
    mem_bus_arbiter #(.CPU_FAIR(1'b0)) u_unfair (.clk(clk), .reset_n(reset_n), .bus(if1));

    always #5 clk = ~clk;

    // {i_gnt, d_gnt, dma_bg, read_m, write_m, i_ack, d_ack, dma_ack}
    logic [7:0] f0, f1;
    assign f0 = {if0.i_gnt, if0.d_gnt, if0.dma_bg, if0.m__read_m, if0.m__write_m,
                 if0.i_ack, if0.d_ack, if0.dma_ack};
    assign f1 = {if1.i_gnt, if1.d_gnt, if1.dma_bg, if1.m__read_m, if1.m__write_m,
                 if1.i_ack, if1.d_ack, if1.dma_ack};

    // in = {i_req, d_rd, d_wr, dma_br, dma_wr, m__ready, m__ack}
    typedef struct {
        logic [6:0]  in;
        logic [15:0] da;
        logic [7:0]  exp;
        logic [15:0] ea;
        logic [63:0] ew;
    } vec_t;

    vec_t vt[32];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [6:0] in, input logic [15:0] da);
        {if0.i_req, if0.d_rd, if0.d_wr, if0.dma_br, if0.dma_wr, if0.m__ready, if0.m__ack} = in;
        if0.dma_addr = da;
    endtask

    initial begin
        // I read alone, latency 3; request held through its ack cycle
        vt[0]  = '{7'b1000010, 16'h0,    8'b10010000, 16'h0040, 64'h0};
        vt[1]  = '{7'b1000010, 16'h0,    8'b10010000, 16'h0040, 64'h0};
        vt[2]  = '{7'b1000010, 16'h0,    8'b10010000, 16'h0040, 64'h0};
        vt[3]  = '{7'b1000011, 16'h0,    8'b00000100, 16'h0,    64'h0};
        vt[4]  = '{7'b1000010, 16'h0,    8'b00000000, 16'h0,    64'h0};
        // I/D round robin: D, I, D, I
        vt[5]  = '{7'b1010010, 16'h0,    8'b01001000, 16'h0100, DWD};
        vt[6]  = '{7'b1010011, 16'h0,    8'b00000010, 16'h0,    64'h0};
        vt[7]  = '{7'b1000010, 16'h0,    8'b10010000, 16'h0040, 64'h0};
        vt[8]  = '{7'b1000011, 16'h0,    8'b00000100, 16'h0,    64'h0};
        vt[9]  = '{7'b0010010, 16'h0,    8'b01001000, 16'h0100, DWD};
        vt[10] = '{7'b1010011, 16'h0,    8'b00000010, 16'h0,    64'h0};
        vt[11] = '{7'b1010010, 16'h0,    8'b10010000, 16'h0040, 64'h0};
        vt[12] = '{7'b1000011, 16'h0,    8'b00000100, 16'h0,    64'h0};
        vt[13] = '{7'b0000010, 16'h0,    8'b00000000, 16'h0,    64'h0};
        // memory not ready holds off the grant
        vt[14] = '{7'b0100000, 16'h0,    8'b00000000, 16'h0,    64'h0};
        vt[15] = '{7'b0100000, 16'h0,    8'b00000000, 16'h0,    64'h0};
        vt[16] = '{7'b0100010, 16'h0,    8'b01010000, 16'h0100, 64'h0};
        vt[17] = '{7'b0100011, 16'h0,    8'b00000010, 16'h0,    64'h0};
        vt[18] = '{7'b0000010, 16'h0,    8'b00000000, 16'h0,    64'h0};
        // DMA burst of three while D read waits
        vt[19] = '{7'b0101010, 16'h0,    8'b00100000, 16'h0,    64'h0};
        vt[20] = '{7'b0101110, 16'h0200, 8'b00101000, 16'h0200, XWD};
        vt[21] = '{7'b0101111, 16'h0200, 8'b00100001, 16'h0,    64'h0};
        vt[22] = '{7'b0101110, 16'h0200, 8'b00100000, 16'h0,    64'h0};
        vt[23] = '{7'b0101110, 16'h0204, 8'b00101000, 16'h0204, XWD};
        vt[24] = '{7'b0101111, 16'h0204, 8'b00100001, 16'h0,    64'h0};
        vt[25] = '{7'b0101010, 16'h0208, 8'b00100000, 16'h0,    64'h0};
        vt[26] = '{7'b0101110, 16'h0208, 8'b00101000, 16'h0208, XWD};
        vt[27] = '{7'b0100111, 16'h0208, 8'b00100001, 16'h0,    64'h0};
        vt[28] = '{7'b0100010, 16'h0,    8'b00000000, 16'h0,    64'h0};
        vt[29] = '{7'b0100010, 16'h0,    8'b01010000, 16'h0100, 64'h0};
        vt[30] = '{7'b0100011, 16'h0,    8'b00000010, 16'h0,    64'h0};
        vt[31] = '{7'b0000010, 16'h0,    8'b00000000, 16'h0,    64'h0};

        apply(7'b0, 16'h0);
        if0.i_addr    = 16'h0040;
        if0.i_size    = 16'h0008;
        if0.d_addr    = 16'h0100;
        if0.d_size    = 16'h0008;
        if0.d_wdata   = DWD;
        if0.dma_size  = 16'h0004;
        if0.dma_wdata = XWD;

        repeat (2) @(negedge clk);
        chk("reset flags", {56'h0, f0}, 64'h0);
        chk("reset addr", {48'h0, if0.m__addr}, 64'h0);
        reset_n = 1'b1;

        for (int i = 0; i < 32; i++) begin
            apply(vt[i].in, vt[i].da);
            @(negedge clk);
            chk($sformatf("vec%0d flags", i), {56'h0, f0}, {56'h0, vt[i].exp});
            if (vt[i].exp[4] || vt[i].exp[3]) begin
                chk($sformatf("vec%0d addr", i), {48'h0, if0.m__addr}, {48'h0, vt[i].ea});
                chk($sformatf("vec%0d wdata", i), if0.m__wdata, vt[i].ew);
            end
        end

        // fairness: DMA re-requests straight after release with I pending
        apply(7'b0001010, 16'h0); @(negedge clk);
        chk("fair grant0", {56'h0, f0}, {56'h0, 8'b00100000});
        chk("unfair grant0", {56'h0, f1}, {56'h0, 8'b00100000});
        apply(7'b0000010, 16'h0); @(negedge clk);
        chk("fair release", {56'h0, f0}, 64'h0);
        chk("unfair release", {56'h0, f1}, 64'h0);
        apply(7'b1001010, 16'h0); @(negedge clk);
        chk("fair cpu first", {56'h0, f0}, {56'h0, 8'b10010000});
        chk("unfair dma first", {56'h0, f1}, {56'h0, 8'b00100000});
        apply(7'b1001011, 16'h0); @(negedge clk);
        chk("fair i_ack", {56'h0, f0}, {56'h0, 8'b00000100});
        chk("unfair ack ignored", {56'h0, f1}, {56'h0, 8'b00100000});
        apply(7'b0001010, 16'h0); @(negedge clk);
        chk("fair dma regrant", {56'h0, f0}, {56'h0, 8'b00100000});
        apply(7'b0000010, 16'h0); @(negedge clk);
        chk("fair dma drop", {56'h0, f0}, 64'h0);

        // reset in the middle of a D write
        apply(7'b0010010, 16'h0); @(negedge clk);
        chk("rst pre busy", {56'h0, f0}, {56'h0, 8'b01001000});
        reset_n = 1'b0;
        #1;
        chk("rst async flags", {56'h0, f0}, 64'h0);
        chk("rst async wdata", if0.m__wdata, 64'h0);
        @(negedge clk);
        chk("rst held flags", {56'h0, f0}, 64'h0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst rearb flags", {56'h0, f0}, {56'h0, 8'b01001000});
        chk("rst rearb wdata", if0.m__wdata, DWD);
        apply(7'b0010011, 16'h0); @(negedge clk);
        chk("rst rearb ack", {56'h0, f0}, {56'h0, 8'b00000010});
        apply(7'b0000010, 16'h0); @(negedge clk);
        chk("final idle", {56'h0, f0}, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
